// File: rtl/ram_fifo.sv
// Synchronous FIFO on a single-write, async-read memory with occupancy, threshold
// flags, sticky error flags, flush, and selectable registered / FWFT read mode.
module ram_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter int DEPTH        = 5000,
  parameter int AFULL_LEVEL  = 4992,
  parameter int AEMPTY_LEVEL = 8,
  parameter int FWFT         = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0]         AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam logic [CW-1:0]         ONE_C    = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    rd_acc      = rd_en_i && !empty_q;
    wr_acc      = wr_en_i && (!full_q || rd_acc);
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q  | (wr_en_i && !wr_acc);
    underflow_d = underflow_q | (rd_en_i && empty_q);
    if (wr_acc && !rd_acc) count_d = count_q + ONE_C;
    else if (!wr_acc && rd_acc) count_d = count_q - ONE_C;
    if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_C);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AFULL_C);
      aempty_q    <= (count_d <= AEMPTY_C);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data_o  = mem_q[rd_ptr_q];
      assign rd_valid_o = !empty_q;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Flush keeps the last output word; only reset clears it.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush_i) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
      end

      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_ram_fifo.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks
// both against a queue-based reference model of the FIFO.
module tb_ram_fifo;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 5;
  localparam int AFULL = 4;
  localparam int AEMPTY = 1;

  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic rd_valid0, rd_valid1;
  logic full0, full1, empty0, empty1, af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [AW:0] count0, count1;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit m_ovf, m_unf, m_rv;
  logic [DW-1:0] m_rd;

  always #5 clk = ~clk;

  ram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL),
             .AEMPTY_LEVEL(AEMPTY), .FWFT(0)) u_dut_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .full_o(full0),
    .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0), .count_o(count0),
    .overflow_o(ovf0), .underflow_o(unf0));

  ram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL),
             .AEMPTY_LEVEL(AEMPTY), .FWFT(1)) u_dut_fwft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .full_o(full1),
    .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1), .count_o(count1),
    .overflow_o(ovf1), .underflow_o(unf1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies the rules of one clock edge to the model, using the inputs sampled at that edge.
  task automatic model_edge();
    bit racc, wacc;
    if (rst) begin
      mq.delete(); m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    end else if (flush) begin
      mq.delete(); m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      racc = rd_en && (mq.size() != 0);
      wacc = wr_en && ((mq.size() != DEPTH) || racc);
      if (rd_en && mq.size() == 0) m_unf = 1;
      if (wr_en && !wacc) m_ovf = 1;
      m_rv = racc;
      if (racc) m_rd = mq.pop_front();
      if (wacc) mq.push_back(wr_data);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check("count_reg",  32'(count0), 32'(n));
    check("count_fwft", 32'(count1), 32'(n));
    check("empty_reg",  32'(empty0), 32'(n == 0));
    check("empty_fwft", 32'(empty1), 32'(n == 0));
    check("full_reg",   32'(full0),  32'(n == DEPTH));
    check("full_fwft",  32'(full1),  32'(n == DEPTH));
    check("afull_reg",  32'(af0),    32'(n >= AFULL));
    check("afull_fwft", 32'(af1),    32'(n >= AFULL));
    check("aempty_reg", 32'(ae0),    32'(n <= AEMPTY));
    check("aempty_fwft",32'(ae1),    32'(n <= AEMPTY));
    check("ovf_reg",    32'(ovf0),   32'(m_ovf));
    check("ovf_fwft",   32'(ovf1),   32'(m_ovf));
    check("unf_reg",    32'(unf0),   32'(m_unf));
    check("unf_fwft",   32'(unf1),   32'(m_unf));
    check("rvalid_reg", 32'(rd_valid0), 32'(m_rv));
    check("rdata_reg",  32'(rd_data0),  32'(m_rd));
    check("rvalid_fwft",32'(rd_valid1), 32'(n != 0));
    if (n != 0) check("rdata_fwft", 32'(rd_data1), 32'(mq[0]));
  endtask

  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                      input logic fl = 1'b0, input logic rs = 1'b0);
    wr_en = wr; wr_data = d; rd_en = rd; flush = fl; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle();

    // Basic order
    for (int i = 0; i < 5; i++) step(1, 8'hA1 + 8'(i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    idle();

    // Wrap-around
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) step(1, 8'h10 + 8'(r * 3 + i), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
    end
    idle();

    // Full boundary: simultaneous write+read on full, then dropped write
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0);
    step(1, 8'hEE, 1);
    step(1, 8'hFF, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    step(0, 0, 0, 1);

    // Empty boundary: read+write on empty
    step(1, 8'h33, 1);
    step(0, 0, 1);
    idle();
    step(0, 0, 0, 1);

    // Fall-through visibility
    step(1, 8'h5A, 0);
    idle();
    step(0, 0, 1);
    idle();

    // Flush with overflow set and 3 words stored
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0);
    step(1, 8'h6F, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 8'h77, 0, 1);
    idle();

    // Same with reset
    for (int i = 0; i < 5; i++) step(1, 8'h80 + 8'(i), 0);
    step(1, 8'h8F, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 8'h99, 0, 0, 1);
    idle();

    // Randomized traffic with varying bias, occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      logic w, r, f, s;
      wp = 20 + ((i / 200) % 4) * 20;
      rp = 80 - ((i / 200) % 4) * 20;
      w = ($urandom_range(99) < wp);
      r = ($urandom_range(99) < rp);
      f = ($urandom_range(59) == 0);
      s = ($urandom_range(299) == 0);
      step(w, 8'($urandom), r, f, s);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
